conv_layer_sched: RTL and testbench
===================================

Name: conv_layer_sched

Overview:
- Top-level sequencer for the binarised CNN convolution datapath. It runs each layer in three phases: load weights into the N_CH parallel conv channels one channel at a time, stream input pixels to all channels, then wait for every channel to finish.
- It generates the shared feature-map write address and write enable, and steps through N_LAYERS conv layers before signalling completion to the FC stage.

Parameters:
- N_CH, 6, number of parallel conv channels (width of weight_en, conv_done, ovalid).
- WLEN, 9, weight words per channel per layer (3x3 kernel).
- IN_LEN, 784, input pixels streamed per layer.
- FMAP_LEN, 144, feature-map entries per channel (12x12).
- N_LAYERS, 2, conv layers per inference.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin inference; sampled only in IDLE.
- w_valid  in  1  weight word valid.
- w_ready  out  1  scheduler accepts a weight word.
- weight_en  out  N_CH  one-hot; selects the channel capturing the current weight word.
- din_valid  in  1  input pixel valid.
- din_ready  out  1  scheduler accepts a pixel; channels capture din on valid&ready.
- conv_start  out  1  one-cycle pulse at each entry to STREAM.
- ovalid  in  N_CH  per-channel result valid; all bits assert together.
- conv_done  in  N_CH  per-channel completion; may be a pulse or a level.
- fmap_we  out  1  feature-map write enable.
- fmap_waddr  out  8  feature-map write address.
- layer_idx  out  1  current layer (0..N_LAYERS-1).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the inference completes.
- ovf  out  1  sticky; a write was attempted past FMAP_LEN-1.

Behaviour:
- Reset values: state IDLE; all outputs 0; all counters 0; done mask 0.
- States: IDLE, LOAD_W, STREAM, WAIT, FIN.

State transitions:
- IDLE: start=1 -> LOAD_W with layer_idx=0, ch_cnt=0, w_cnt=0, ovf cleared. start in any other state is ignored.
- LOAD_W:
  - w_ready=1; weight_en = 1<<ch_cnt.
  - On w_valid&w_ready, w_cnt increments.
  - At w_cnt=WLEN-1 with a handshake: w_cnt->0 and ch_cnt increments.
  - After the last word of channel N_CH-1: -> STREAM.
  - weight_en is 0 outside LOAD_W.
- STREAM:
  - conv_start=1 on the first cycle only.
  - din_ready=1; pix_cnt increments on each handshake.
  - The handshake at pix_cnt=IN_LEN-1 -> WAIT, and din_ready drops the next cycle.
- WAIT:
  - din_ready=0.
  - The done mask ORs in conv_done every cycle in STREAM and WAIT, so pulses are never lost.
  - When the mask is all ones: clear the mask, pix_cnt and fmap_waddr.
  - If layer_idx=N_LAYERS-1 -> FIN; otherwise increment layer_idx and -> LOAD_W.
- FIN: done=1 for exactly one cycle -> IDLE. layer_idx holds its value until the next start.

Feature-map writes:
- In STREAM and WAIT only, fmap_we = ovalid[0] combinationally.
- fmap_waddr increments on the cycle after each write.
- A write with fmap_waddr=FMAP_LEN-1 leaves the address saturated.
- Any ovalid while saturated sets ovf and suppresses fmap_we.
- ovalid in IDLE, LOAD_W or FIN is ignored.

Simultaneous events and reset:
- conv_done in the same cycle as the last pixel is captured.
- Mismatched ovalid bits have no defined effect; only bit 0 is used.
- Reset mid-operation returns to IDLE immediately and drops every handshake output in the same cycle (asynchronous).

Counter widths are $clog2-sized; they never overflow because of the terminal compares.

Test Plan:
- Reset held for 3 cycles, then released: busy, done, w_ready, din_ready, weight_en, fmap_we all 0.
- start, w_valid held high:
  - weight_en steps 000001 to 100000, 9 cycles each (54 cycles total).
  - conv_start pulses once.
  - 784 din handshakes follow, with din_valid toggling 50%: pix_cnt reaches 784 and din_ready then drops.
- In WAIT, pulse conv_done bits one per cycle in the order 0,3,5,1,2,4 -> transition to LOAD_W with layer_idx=1 only after the 6th pulse.
- 144 ovalid pulses in layer 0: fmap_waddr runs 0..143, ovf stays 0. A 145th pulse sets ovf and gives fmap_we=0.
- Full 2-layer run: done pulses once, 1 cycle after the final conv_done, then the block returns to IDLE. start asserted during STREAM changes nothing.
- rstn asserted during layer 1 STREAM:
  - Outputs clear asynchronously.
  - A new start runs layer 0 from channel 0 with fmap_waddr=0.

Source files
------------

// File: rtl/conv_layer_sched.sv
//============================================================================
// conv_layer_sched
//
// Top-level sequencer for the binarised CNN convolution datapath. Each conv
// layer runs in three phases:
//   LOAD_W : weight words are handed to the N_CH conv channels one channel at
//            a time (WLEN words per channel, selected by one-hot weight_en).
//   STREAM : IN_LEN input pixels are broadcast to all channels.
//   WAIT   : the scheduler waits until every channel has reported completion.
// After N_LAYERS layers a one-cycle done pulse is issued to the FC stage.
// The block also owns the shared feature-map write port (fmap_we/fmap_waddr)
// and flags any write attempted beyond the end of the feature map (ovf).
//
// Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset
//   start       begin an inference (only honoured while idle)
//   w_valid     weight word valid          w_ready    weight word accepted
//   weight_en   one-hot channel select for the current weight word
//   din_valid   input pixel valid          din_ready  input pixel accepted
//   conv_start  one-cycle pulse on every entry to the streaming phase
//   ovalid      per-channel result valid (only bit 0 is used)
//   conv_done   per-channel completion, pulse or level
//   fmap_we     feature-map write enable (combinational from ovalid[0])
//   fmap_waddr  feature-map write address
//   layer_idx   layer currently being processed
//   busy        high whenever the scheduler is not idle
//   done        one-cycle pulse when the inference completes
//   ovf         sticky flag: a write was attempted past the last entry
//============================================================================
module conv_layer_sched #(
  parameter int N_CH     = 6,
  parameter int WLEN     = 9,
  parameter int IN_LEN   = 784,
  parameter int FMAP_LEN = 144,
  parameter int N_LAYERS = 2,
  parameter int LAYER_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               w_valid,
  output logic               w_ready,
  output logic [N_CH-1:0]    weight_en,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               conv_start,
  input  logic [N_CH-1:0]    ovalid,
  input  logic [N_CH-1:0]    conv_done,
  output logic               fmap_we,
  output logic [7:0]         fmap_waddr,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int WC_W  = $clog2(WLEN);
  localparam int PIX_W = $clog2(IN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch_cnt;
  logic [WC_W-1:0]   w_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [N_CH-1:0]   done_mask;
  logic              fmap_sat;

  logic              w_hs;
  logic              d_hs;
  logic              in_conv;
  logic              ovalid_hit;
  logic [N_CH-1:0]   mask_next;
  logic              layer_end;
  logic              ovalid_hi_unused;

  // Handshakes use the registered ready outputs, so a transfer is exactly
  // what the upstream source sees as valid&ready.
  assign w_hs = w_valid & w_ready;
  assign d_hs = din_valid & din_ready;

  // Channel results can only arrive while a layer is streaming or draining.
  assign in_conv    = (state == STREAM) || (state == WAIT);
  assign ovalid_hit = in_conv & ovalid[0];

  // The current cycle's conv_done is folded in before the all-ones test, so a
  // final completion pulse ends the layer on the same edge it is seen.
  assign mask_next = done_mask | conv_done;
  assign layer_end = (state == WAIT) && (&mask_next);

  // All channels raise ovalid together; bit 0 stands in for the group.
  assign ovalid_hi_unused = ^ovalid[N_CH-1:1];

  // Once the last entry has been written the address is frozen and further
  // results are dropped instead of overwriting entry FMAP_LEN-1.
  assign fmap_we = ovalid_hit & ~fmap_sat;

  // Main sequencer. Every handshake/status output is registered together
  // with the state so the outputs always describe the state being occupied.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      w_ready    <= 1'b0;
      weight_en  <= '0;
      din_ready  <= 1'b0;
      conv_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      layer_idx  <= '0;
      ch_cnt     <= '0;
      w_cnt      <= '0;
      pix_cnt    <= '0;
    end else begin
      conv_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_W;
            busy      <= 1'b1;
            w_ready   <= 1'b1;
            weight_en <= N_CH'(1);
            layer_idx <= '0;
            ch_cnt    <= '0;
            w_cnt     <= '0;
            pix_cnt   <= '0;
          end
        end

        LOAD_W: begin
          if (w_hs) begin
            if (w_cnt == WC_W'(WLEN - 1)) begin
              w_cnt <= '0;
              if (ch_cnt == CH_W'(N_CH - 1)) begin
                ch_cnt     <= '0;
                state      <= STREAM;
                w_ready    <= 1'b0;
                weight_en  <= '0;
                din_ready  <= 1'b1;
                conv_start <= 1'b1;
              end else begin
                ch_cnt    <= ch_cnt + 1'b1;
                weight_en <= weight_en << 1;
              end
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end

        STREAM: begin
          if (d_hs) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == PIX_W'(IN_LEN - 1)) begin
              state     <= WAIT;
              din_ready <= 1'b0;
            end
          end
        end

        WAIT: begin
          if (layer_end) begin
            pix_cnt <= '0;
            if (layer_idx == LAYER_W'(N_LAYERS - 1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              layer_idx <= layer_idx + 1'b1;
              state     <= LOAD_W;
              w_ready   <= 1'b1;
              weight_en <= N_CH'(1);
            end
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          w_ready   <= 1'b0;
          weight_en <= '0;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

  // Completion mask. Channels may report with a single-cycle pulse that can
  // arrive as early as the last pixel, so bits are accumulated through both
  // STREAM and WAIT and only cleared once the whole layer has finished.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_mask <= '0;
    end else if (layer_end) begin
      done_mask <= '0;
    end else if (in_conv) begin
      done_mask <= mask_next;
    end
  end

  // Feature-map address generation. The address advances after each write
  // and sticks at the last entry; a result arriving while stuck raises ovf,
  // which stays set until the next inference is started.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fmap_waddr <= '0;
      fmap_sat   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        ovf <= 1'b0;
      end else if (ovalid_hit && fmap_sat) begin
        ovf <= 1'b1;
      end

      if (layer_end) begin
        fmap_waddr <= '0;
        fmap_sat   <= 1'b0;
      end else if (ovalid_hit && !fmap_sat) begin
        if (fmap_waddr == 8'(FMAP_LEN - 1)) begin
          fmap_sat <= 1'b1;
        end else begin
          fmap_waddr <= fmap_waddr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
//============================================================================
// tb_conv_layer_sched
//
// Scoreboard bench for conv_layer_sched. Stimulus tasks push the expected
// weight channel for every weight word, the expected feature-map address for
// every result pulse, and the expected layer for the done pulse; a negedge
// monitor pops and compares whenever the DUT presents the matching output.
// Timing-related behaviour (phase lengths, ready drops, WAIT hold-off, reset)
// is checked directly by the stimulus tasks.
//============================================================================
module tb_conv_layer_sched;

  localparam int N_CH     = 6;
  localparam int WLEN     = 9;
  localparam int IN_LEN   = 784;
  localparam int FMAP_LEN = 144;
  localparam int N_LAYERS = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic            w_valid = 1'b0;
  logic            din_valid = 1'b0;
  logic [N_CH-1:0] ovalid = '0;
  logic [N_CH-1:0] conv_done = '0;
  logic            w_ready;
  logic [N_CH-1:0] weight_en;
  logic            din_ready;
  logic            conv_start;
  logic            fmap_we;
  logic [7:0]      fmap_waddr;
  logic [0:0]      layer_idx;
  logic            busy;
  logic            done;
  logic            ovf;

  int vectors = 0;
  int miscompares = 0;

  logic [N_CH-1:0] exp_wen_q[$];
  int              exp_waddr_q[$];
  int              exp_done_q[$];

  int cstart_cnt = 0;
  int done_cnt = 0;
  int stream_entries = 0;
  int wr_in_layer = 0;
  bit ovf_model = 1'b0;

  conv_layer_sched #(
    .N_CH(N_CH), .WLEN(WLEN), .IN_LEN(IN_LEN),
    .FMAP_LEN(FMAP_LEN), .N_LAYERS(N_LAYERS)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .w_valid(w_valid), .w_ready(w_ready), .weight_en(weight_en),
    .din_valid(din_valid), .din_ready(din_ready), .conv_start(conv_start),
    .ovalid(ovalid), .conv_done(conv_done),
    .fmap_we(fmap_we), .fmap_waddr(fmap_waddr), .layer_idx(layer_idx),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Absolute time limit so a stuck DUT can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got %0d vectors, required completion", vectors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic reportUnexpected(input string name, input longint actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got %0d with nothing expected (t=%0t)", name, actual, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a layer's weights go to channel 0 first, WLEN words per
  // channel, in ascending channel order.
  task automatic pushLayerWeights();
    for (int ch = 0; ch < N_CH; ch++)
      for (int w = 0; w < WLEN; w++)
        exp_wen_q.push_back(N_CH'(1) << ch);
  endtask

  // Reference model: the k-th result of a layer lands at address k; results
  // beyond the feature-map size are dropped and flag overflow.
  task automatic issueOvalid();
    if (wr_in_layer < FMAP_LEN) exp_waddr_q.push_back(wr_in_layer);
    else ovf_model = 1'b1;
    wr_in_layer++;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rstn) begin
      if (w_valid && w_ready) begin
        if (exp_wen_q.size() == 0) reportUnexpected("weight_en_extra", weight_en);
        else checkOutput("weight_en", weight_en, exp_wen_q.pop_front());
      end
      if (fmap_we) begin
        if (exp_waddr_q.size() == 0) reportUnexpected("fmap_we_extra", fmap_waddr);
        else checkOutput("fmap_waddr", fmap_waddr, exp_waddr_q.pop_front());
      end
      if (conv_start) cstart_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) reportUnexpected("done_extra", layer_idx);
        else checkOutput("done_layer_idx", layer_idx, exp_done_q.pop_front());
      end
    end
  end

  task automatic loadWeights(input bit full_rate, output int cycles);
    int accepted = 0;
    cycles = 0;
    pushLayerWeights();
    while (accepted < N_CH * WLEN && cycles < 2000) begin
      w_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
      if (w_valid && w_ready) accepted++;
      tick();
      cycles++;
    end
    w_valid = 1'b0;
    if (accepted != N_CH * WLEN) checkOutput("wload_timeout", accepted, N_CH * WLEN);
    checkOutput("w_ready_after_load", w_ready, 0);
    checkOutput("weight_en_after_load", weight_en, 0);
  endtask

  task automatic streamPixels(input bit rnd_start, input int n_ov, input logic [N_CH-1:0] last_done,
                              input int stop_after, output int ov_left);
    int sent = 0;
    int cyc = 0;
    ov_left = n_ov;
    stream_entries++;
    checkOutput("conv_start_first", conv_start, 1);
    checkOutput("din_ready_entry", din_ready, 1);
    while (sent < IN_LEN && cyc < 8 * IN_LEN && (stop_after == 0 || cyc < stop_after)) begin
      din_valid = 1'($urandom_range(0, 1));
      if (ov_left > 0 && $urandom_range(0, 7) == 0) begin
        ovalid = '1;
        issueOvalid();
        ov_left--;
      end else begin
        ovalid = '0;
      end
      start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      conv_done = (din_valid && din_ready && sent == IN_LEN - 1) ? last_done : '0;
      if (cyc == 1) checkOutput("conv_start_once", conv_start, 0);
      if (din_valid && din_ready) sent++;
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    ovalid = '0;
    start = 1'b0;
    conv_done = '0;
    if (stop_after == 0) begin
      if (sent != IN_LEN) checkOutput("stream_timeout", sent, IN_LEN);
      checkOutput("din_ready_drop", din_ready, 0);
    end
  endtask

  // mode 0: fixed order 0,3,5,1,2,4; mode 1: only bit 5 (others already
  // delivered with the last pixel); mode 2: random order with idle gaps.
  task automatic waitPhase(input int layer, input int n_ov, input int mode);
    int order[$];
    int j;
    int t;
    int gap;
    logic [N_CH-1:0] one = 1;
    for (int k = 0; k < n_ov; k++) begin
      if (wr_in_layer == FMAP_LEN) checkOutput("ovf_before_sat", ovf, 0);
      ovalid = '1;
      issueOvalid();
      #1;
      if (wr_in_layer > FMAP_LEN) checkOutput("fmap_we_suppressed", fmap_we, 0);
      tick();
    end
    ovalid = '0;
    if (n_ov > 0) checkOutput("ovf_state", ovf, ovf_model);

    if (mode == 0) order = '{0, 3, 5, 1, 2, 4};
    else if (mode == 1) order = '{5};
    else begin
      for (int b = 0; b < N_CH; b++) order.push_back(b);
      for (int i = N_CH - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
    end

    for (int i = 0; i < order.size(); i++) begin
      if (i == order.size() - 1 && layer == N_LAYERS - 1) exp_done_q.push_back(layer);
      conv_done = one << order[i];
      tick();
      conv_done = '0;
      if (i != order.size() - 1) begin
        checkOutput("wait_hold_w_ready", w_ready, 0);
        checkOutput("wait_hold_done", done, 0);
        gap = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gap; g++) begin
          tick();
          checkOutput("wait_gap_w_ready", w_ready, 0);
        end
      end
    end

    if (layer < N_LAYERS - 1) begin
      checkOutput("next_layer_w_ready", w_ready, 1);
      checkOutput("next_layer_idx", layer_idx, layer + 1);
    end else begin
      checkOutput("done_pulse", done, 1);
      checkOutput("busy_in_fin", busy, 1);
      tick();
      checkOutput("done_cleared", done, 0);
      checkOutput("busy_idle", busy, 0);
      checkOutput("layer_idx_hold", layer_idx, N_LAYERS - 1);
    end
  endtask

  // One complete (or truncated) layer: entry checks, weights, pixels, drain.
  task automatic applyStimulus(input int layer, input bit w_full, input bit rnd_start,
                               input int n_ov_stream, input int n_ov_wait, input int mode,
                               input logic [N_CH-1:0] last_done, input int stop_after);
    int wc;
    int ov_left;
    wr_in_layer = 0;
    checkOutput("layer_idx_entry", layer_idx, layer);
    checkOutput("w_ready_entry", w_ready, 1);
    checkOutput("weight_en_entry", weight_en, 1);
    loadWeights(w_full, wc);
    if (w_full) checkOutput("wload_cycles", wc, N_CH * WLEN);
    streamPixels(rnd_start, n_ov_stream, last_done, stop_after, ov_left);
    if (stop_after == 0) waitPhase(layer, n_ov_wait + ov_left, mode);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_w_ready"}, w_ready, 0);
    checkOutput({tag, "_din_ready"}, din_ready, 0);
    checkOutput({tag, "_weight_en"}, weight_en, 0);
    checkOutput({tag, "_fmap_we"}, fmap_we, 0);
    checkOutput({tag, "_conv_start"}, conv_start, 0);
    checkOutput({tag, "_fmap_waddr"}, fmap_waddr, 0);
    checkOutput({tag, "_layer_idx"}, layer_idx, 0);
  endtask

  task automatic startInference(input bit keep_start);
    start = 1'b1;
    tick();
    start = keep_start;
    ovf_model = 1'b0;
    checkOutput("ovf_cleared_on_start", ovf, 0);
    checkOutput("busy_after_start", busy, 1);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    checkIdleOutputs("reset");
    checkOutput("reset_ovf", ovf, 0);

    // Run 1: start and w_valid held high, start toggled during layer 0
    // streaming, 145 results in layer 0 to reach overflow.
    $display("[TB] run 1: full-rate weights, overflow, two layers");
    startInference(1'b1);
    applyStimulus(0, 1'b1, 1'b1, 100, 45, 0, '0, 0);
    applyStimulus(1, 1'b0, 1'b0, 30, 0, 1, 6'b011111, 0);
    checkOutput("run1_idle_w_ready", w_ready, 0);

    // Run 2: reset asserted in the middle of layer 1 streaming.
    $display("[TB] run 2: asynchronous reset during layer 1");
    startInference(1'b0);
    applyStimulus(0, 1'b0, 1'b0, 10, 0, 2, '0, 0);
    applyStimulus(1, 1'b0, 1'b0, 5, 0, 2, '0, 200);
    #3;
    rstn = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();

    // Run 3: restart after reset must begin at layer 0, channel 0, address 0.
    $display("[TB] run 3: restart after reset");
    startInference(1'b0);
    applyStimulus(0, 1'b0, 1'b0, 25, 0, 2, '0, 0);
    applyStimulus(1, 1'b0, 1'b1, 15, 3, 2, '0, 0);

    repeat (3) tick();
    checkOutput("wen_queue_drained", exp_wen_q.size(), 0);
    checkOutput("waddr_queue_drained", exp_waddr_q.size(), 0);
    checkOutput("done_queue_drained", exp_done_q.size(), 0);
    checkOutput("conv_start_pulses", cstart_cnt, stream_entries);
    checkOutput("done_pulses", done_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
